// File: rtl/mem_req_bridge_if.sv
// CPU-side handshakes and ideal-memory raw port signals for mem_req_bridge.
// master = core plus memory side, slave = the bridge.
interface mem_req_bridge_if #(
  parameter int ADDR_WIDTH = 14
);
  // Handshake rule for every req/rsp pair: a transfer happens on a clk edge
  // where valid and ready are both 1. Valid may drop before it is accepted.
  // Ready asserted while valid is 0 has no effect.
  logic                  inst_req_valid;
  logic                  inst_req_ready;
  logic [31:0]           inst_addr;
  logic                  inst_rsp_valid;
  logic                  inst_rsp_ready;
  logic [31:0]           inst_rdata;

  logic                  data_req_valid;
  logic                  data_req_ready;
  logic                  data_req_wen;
  logic [31:0]           data_addr;
  logic [31:0]           data_wdata;
  logic                  data_rsp_valid;
  logic                  data_rsp_ready;
  logic [31:0]           data_rdata;

  logic [ADDR_WIDTH-3:0] Raddr1;
  logic                  Rden1;
  logic [31:0]           Rdata1;
  logic [ADDR_WIDTH-3:0] Raddr2;
  logic                  Rden2;
  logic [31:0]           Rdata2;
  logic [ADDR_WIDTH-3:0] Waddr;
  logic                  Wren;
  logic [31:0]           Wdata;

  modport master (
    output inst_req_valid, inst_addr, inst_rsp_ready,
    output data_req_valid, data_req_wen, data_addr, data_wdata, data_rsp_ready,
    output Rdata1, Rdata2,
    input  inst_req_ready, inst_rsp_valid, inst_rdata,
    input  data_req_ready, data_rsp_valid, data_rdata,
    input  Raddr1, Rden1, Raddr2, Rden2, Waddr, Wren, Wdata
  );

  modport slave (
    input  inst_req_valid, inst_addr, inst_rsp_ready,
    input  data_req_valid, data_req_wen, data_addr, data_wdata, data_rsp_ready,
    input  Rdata1, Rdata2,
    output inst_req_ready, inst_rsp_valid, inst_rdata,
    output data_req_ready, data_rsp_valid, data_rdata,
    output Raddr1, Rden1, Raddr2, Rden2, Waddr, Wren, Wdata
  );
endinterface

// File: rtl/mem_req_bridge.sv
// Valid/ready to ideal-memory bridge with programmable access latency (LATENCY 1..15).
// Optional wait-cycle counters are built when MEM_BRIDGE_PERF_EN is defined.
module mem_req_bridge #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 3
) (
  input  logic               clk,
  input  logic               resetn,
  mem_req_bridge_if.slave    bus,
  output logic [31:0]        inst_wait_cnt,
  output logic [31:0]        data_wait_cnt,
  output logic [1:0]         inst_state_dbg,
  output logic [1:0]         data_state_dbg
);
  localparam int         WW       = ADDR_WIDTH - 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        i_state_q, i_state_d;
  logic [3:0]    i_cnt_q, i_cnt_d;
  logic [WW-1:0] i_addr_q, i_addr_d;
  logic [31:0]   i_rdata_q, i_rdata_d;

  state_e        d_state_q, d_state_d;
  logic [3:0]    d_cnt_q, d_cnt_d;
  logic [WW-1:0] d_addr_q, d_addr_d;
  logic          d_wen_q, d_wen_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  logic          i_access;
  logic          d_access;

  // Byte-lane and above-memory address bits are dropped, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_addr[31:ADDR_WIDTH], bus.inst_addr[1:0],
                              bus.data_addr[31:ADDR_WIDTH], bus.data_addr[1:0]};

  // The single memory access cycle of a transaction: last WAIT cycle.
  assign i_access = (i_state_q == S_WAIT) && (i_cnt_q == 4'd0);
  assign d_access = (d_state_q == S_WAIT) && (d_cnt_q == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_state_q <= S_IDLE;
      i_cnt_q   <= '0;
      i_addr_q  <= '0;
      i_rdata_q <= '0;
      d_state_q <= S_IDLE;
      d_cnt_q   <= '0;
      d_addr_q  <= '0;
      d_wen_q   <= 1'b0;
      d_wdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_addr_q  <= i_addr_d;
      i_rdata_q <= i_rdata_d;
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_addr_q  <= d_addr_d;
      d_wen_q   <= d_wen_d;
      d_wdata_q <= d_wdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_addr_d  = i_addr_q;
    i_rdata_d = i_rdata_q;
    case (i_state_q)
      S_IDLE: begin
        if (bus.inst_req_valid) begin
          i_addr_d  = bus.inst_addr[ADDR_WIDTH-1:2];
          i_cnt_d   = CNT_LOAD;
          i_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_cnt_q != 4'd0) begin
          i_cnt_d = i_cnt_q - 4'd1;
        end else begin
          i_rdata_d = bus.Rdata1;
          i_state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.inst_rsp_ready) i_state_d = S_IDLE;
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_addr_d  = d_addr_q;
    d_wen_d   = d_wen_q;
    d_wdata_d = d_wdata_q;
    d_rdata_d = d_rdata_q;
    case (d_state_q)
      S_IDLE: begin
        if (bus.data_req_valid) begin
          d_addr_d  = bus.data_addr[ADDR_WIDTH-1:2];
          d_wen_d   = bus.data_req_wen;
          d_wdata_d = bus.data_wdata;
          d_cnt_d   = CNT_LOAD;
          d_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_cnt_q != 4'd0) begin
          d_cnt_d = d_cnt_q - 4'd1;
        end else begin
          // Stores complete with zero read data.
          d_rdata_d = d_wen_q ? 32'd0 : bus.Rdata2;
          d_state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.data_rsp_ready) d_state_d = S_IDLE;
      end
      default: d_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Ready is gated by resetn so it reads 0 while reset is held.
    bus.inst_req_ready = resetn && (i_state_q == S_IDLE);
    bus.inst_rsp_valid = (i_state_q == S_RESP);
    bus.inst_rdata     = i_rdata_q;
    bus.Raddr1         = i_addr_q;
    bus.Rden1          = i_access;

    bus.data_req_ready = resetn && (d_state_q == S_IDLE);
    bus.data_rsp_valid = (d_state_q == S_RESP);
    bus.data_rdata     = d_rdata_q;
    bus.Raddr2         = d_addr_q;
    bus.Rden2          = d_access && !d_wen_q;
    bus.Waddr          = d_addr_q;
    bus.Wren           = d_access && d_wen_q;
    bus.Wdata          = d_wdata_q;

    inst_state_dbg     = i_state_q;
    data_state_dbg     = d_state_q;
  end

`ifdef MEM_BRIDGE_PERF_EN
  logic [31:0] i_wait_q, i_wait_d;
  logic [31:0] d_wait_q, d_wait_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_wait_q <= '0;
      d_wait_q <= '0;
    end else begin
      i_wait_q <= i_wait_d;
      d_wait_q <= d_wait_d;
    end
  end

  // Counts every cycle a channel is busy (WAIT or RESP); wraps naturally.
  always_comb begin
    i_wait_d = i_wait_q + ((i_state_q != S_IDLE) ? 32'd1 : 32'd0);
    d_wait_d = d_wait_q + ((d_state_q != S_IDLE) ? 32'd1 : 32'd0);
  end

  assign inst_wait_cnt = i_wait_q;
  assign data_wait_cnt = d_wait_q;
`else
  assign inst_wait_cnt = '0;
  assign data_wait_cnt = '0;
`endif

endmodule
